// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the PC, issues a req/ack memory read,
// captures the word and presents its register fields until decode takes it.
module fetch_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_addr,
    input  logic        flush,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        pc_inc,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [3:0]  opcode,
    output logic [2:0]  rd_add,
    output logic [2:0]  ra_add,
    output logic [2:0]  rb_add,
    output logic [2:0]  funct,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        FAULT
    } state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      r_state, w_state;
    logic [7:0]  r_cnt, w_cnt;
    logic        r_req, w_req;
    logic [15:0] r_addr, w_addr;
    logic        r_inc, w_inc;
    logic [15:0] r_instr, w_instr;
    logic        r_valid, w_valid;
    logic        r_fault, w_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_inc   <= 1'b0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_req   <= w_req;
            r_addr  <= w_addr;
            r_inc   <= w_inc;
            r_instr <= w_instr;
            r_valid <= w_valid;
            r_fault <= w_fault;
        end
    end

    // pc_inc defaults low so it can only ever be a single-cycle pulse
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_req   = r_req;
        w_addr  = r_addr;
        w_inc   = 1'b0;
        w_instr = r_instr;
        w_valid = r_valid;
        w_fault = r_fault;
        if (flush) begin
            w_state = IDLE;
            w_req   = 1'b0;
            w_valid = 1'b0;
            w_cnt   = '0;
            w_fault = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (pc_addr[0]) begin
                        w_state = FAULT;
                        w_fault = 1'b1;
                    end else begin
                        w_addr  = pc_addr;
                        w_req   = 1'b1;
                        w_cnt   = '0;
                        w_state = FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        w_instr = mem_rdata;
                        w_valid = 1'b1;
                        w_inc   = 1'b1;
                        w_req   = 1'b0;
                        w_state = HOLD;
                    end else if (r_cnt == LAST) begin
                        w_req   = 1'b0;
                        w_fault = 1'b1;
                        w_state = FAULT;
                    end else begin
                        w_cnt = r_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (r_valid && instr_ready) begin
                        w_valid = 1'b0;
                        w_state = IDLE;
                    end
                end
                FAULT: begin
                    w_fault = 1'b1;
                    w_req   = 1'b0;
                    w_valid = 1'b0;
                end
                default: w_state = IDLE;
            endcase
        end
    end

    assign mem_req     = r_req;
    assign mem_addr    = r_addr;
    assign pc_inc      = r_inc;
    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign fault       = r_fault;
    assign opcode      = r_instr[15:12];
    assign rd_add      = r_instr[11:9];
    assign ra_add      = r_instr[8:6];
    assign rb_add      = r_instr[5:3];
    assign funct       = r_instr[2:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed corner cases, then random memory latency
// and backpressure against a PC/ROM model with a scoreboard queue.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc_addr = '0;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        pc_inc;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [3:0]  opcode;
    logic [2:0]  rd_add, ra_add, rb_add, funct;
    logic        fault;

    fetch_unit #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .pc_inc(pc_inc), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .rd_add(rd_add), .ra_add(ra_add),
        .rb_add(rb_add), .funct(funct), .fault(fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int inc_cnt = 0;
    int hs_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] rom[256];
    logic [15:0] pc_model = '0;
    logic [15:0] mon_e;
    bit auto_mem = 0, mem_stop = 0, rand_ready = 0, mem_busy = 0;
    bit prev_inc = 0;
    int mem_wait = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory answers from the address the DUT drives; expectation comes
    // from the register-file PC model.
    task automatic ack_now();
        mem_ack = 1'b1;
        mem_rdata = rom[mem_addr[8:1]];
        exp_q.push_back(rom[pc_model[8:1]]);
    endtask

    task automatic step();
        bit inc;
        inc = (pc_inc === 1'b1);
        @(posedge clk);
        #1;
        if (inc) pc_model += 16'd2;
        pc_addr = pc_model;
        mem_ack = 1'b0;
        if (rand_ready) instr_ready = 1'($urandom);
        if (auto_mem) begin
            if (mem_req && !mem_busy && !mem_stop) begin
                mem_busy = 1;
                mem_wait = $urandom_range(0, 3);
            end
            if (mem_busy) begin
                if (mem_wait == 0) begin
                    ack_now();
                    mem_busy = 0;
                end else begin
                    mem_wait--;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (pc_inc === 1'b1) begin
                inc_cnt++;
                chk("pc_inc_pulse", 32'(prev_inc), 0);
            end
            prev_inc = (pc_inc === 1'b1);
            if (instr_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    mon_e = exp_q[0];
                    chk("sb_instr", 32'(instr), 32'(mon_e));
                    chk("sb_opcode", 32'(opcode), 32'(mon_e[15:12]));
                    chk("sb_rd", 32'(rd_add), 32'(mon_e[11:9]));
                    chk("sb_ra", 32'(ra_add), 32'(mon_e[8:6]));
                    chk("sb_rb", 32'(rb_add), 32'(mon_e[5:3]));
                    chk("sb_funct", 32'(funct), 32'(mon_e[2:0]));
                    if (instr_ready && !flush) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
        end else begin
            prev_inc = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int i0, h0, nreq;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h1A5B;

        step();
        step();
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_inc", 32'(pc_inc), 0);
        chk("rst_fault", 32'(fault), 0);
        chk("rst_opcode", 32'(opcode), 0);

        rst = 1'b0;
        instr_ready = 1'b1;
        step();
        chk("basic_req", 32'(mem_req), 1);
        chk("basic_addr", 32'(mem_addr), 0);
        step();
        step();
        chk("basic_req_held", 32'(mem_req), 1);
        ack_now();
        step();
        chk("basic_valid", 32'(instr_valid), 1);
        chk("basic_inc", 32'(pc_inc), 1);
        chk("basic_instr", 32'(instr), 32'h1A5B);
        chk("basic_op", 32'(opcode), 1);
        chk("basic_rd", 32'(rd_add), 5);
        chk("basic_ra", 32'(ra_add), 1);
        chk("basic_rb", 32'(rb_add), 3);
        chk("basic_funct", 32'(funct), 3);
        step();
        chk("basic_valid_1cyc", 32'(instr_valid), 0);
        chk("basic_inc_1cyc", 32'(pc_inc), 0);

        step();
        chk("bp_req", 32'(mem_req), 1);
        chk("bp_addr", 32'(mem_addr), 2);
        instr_ready = 1'b0;
        i0 = inc_cnt;
        ack_now();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(instr_valid), 1);
            chk("bp_no_req", 32'(mem_req), 0);
            chk("bp_instr", 32'(instr), 32'(rom[1]));
            step();
        end
        instr_ready = 1'b1;
        chk("bp_valid_last", 32'(instr_valid), 1);
        step();
        chk("bp_valid_drop", 32'(instr_valid), 0);
        chk("bp_one_inc", 32'(inc_cnt - i0), 1);

        pc_model = 16'h0003;
        pc_addr = pc_model;
        step();
        chk("mis_fault", 32'(fault), 1);
        chk("mis_no_req", 32'(mem_req), 0);
        step();
        step();
        chk("mis_sticky", 32'(fault), 1);
        chk("mis_no_req2", 32'(mem_req), 0);
        pc_model = 16'h0004;
        pc_addr = pc_model;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("mis_flush_clr", 32'(fault), 0);
        step();
        chk("mis_restart_req", 32'(mem_req), 1);
        chk("mis_restart_addr", 32'(mem_addr), 4);

        nreq = 1;
        for (int i = 0; i < 40 && mem_req; i++) begin
            step();
            if (mem_req) nreq++;
        end
        chk("to_req_cycles", 32'(nreq), 15);
        chk("to_fault", 32'(fault), 1);
        pc_model = 16'h0006;
        pc_addr = pc_model;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("to2_req", 32'(mem_req), 1);
        chk("to2_addr", 32'(mem_addr), 6);
        repeat (14) step();
        chk("to2_req_c15", 32'(mem_req), 1);
        ack_now();
        step();
        chk("to2_valid", 32'(instr_valid), 1);
        chk("to2_no_fault", 32'(fault), 0);
        chk("to2_instr", 32'(instr), 32'(rom[3]));
        step();

        step();
        chk("fl_req", 32'(mem_req), 1);
        chk("fl_addr", 32'(mem_addr), 8);
        mem_ack = 1'b1;
        mem_rdata = 16'hFFFF;
        flush = 1'b1;
        i0 = inc_cnt;
        step();
        flush = 1'b0;
        chk("fl_valid", 32'(instr_valid), 0);
        chk("fl_inc", 32'(pc_inc), 0);
        chk("fl_req_drop", 32'(mem_req), 0);
        pc_model = 16'h0020;
        pc_addr = pc_model;
        step();
        chk("fl_new_req", 32'(mem_req), 1);
        chk("fl_new_addr", 32'(mem_addr), 32'h20);
        step();
        chk("fl_no_inc", 32'(inc_cnt - i0), 0);

        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_req", 32'(mem_req), 0);
        chk("mrst_addr", 32'(mem_addr), 0);
        chk("mrst_valid", 32'(instr_valid), 0);
        chk("mrst_instr", 32'(instr), 0);
        chk("mrst_fault", 32'(fault), 0);
        mem_ack = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        chk("stray_valid", 32'(instr_valid), 0);
        chk("stray_inc", 32'(pc_inc), 0);
        chk("stray_req", 32'(mem_req), 1);
        chk("stray_addr", 32'(mem_addr), 32'h20);
        step();
        chk("stray_valid2", 32'(instr_valid), 0);

        i0 = inc_cnt;
        h0 = hs_cnt;
        auto_mem = 1;
        rand_ready = 1;
        repeat (800) step();
        mem_stop = 1;
        rand_ready = 0;
        instr_ready = 1'b1;
        for (int i = 0; i < 100 && (mem_busy || exp_q.size() != 0 || instr_valid); i++)
            step();
        chk("rnd_drained", 32'(exp_q.size()), 0);
        chk("rnd_inc_vs_hs", 32'(inc_cnt - i0), 32'(hs_cnt - h0));
        chk("rnd_progress", 32'((hs_cnt - h0) > 50), 1);
        chk("rnd_no_fault", 32'(fault), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
